otter_io_harness: RTL and testbench

//  Parametrised IOBUS harness for OTTER_MCU. Replaces ad-hoc free-running reset and input stimulus.

---
 rtl/otter_io_harness.sv | 141 ++++++++++++++
 tb/tb_otter_io_harness.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_io_harness.sv
// otter_io_harness: IOBUS harness for OTTER_MCU -- reset stretcher, memory-mapped
// word channels and a first-word-fall-through log of every accepted MCU write.
module otter_io_harness #(
  parameter int unsigned NUM_CH     = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned LOG_DEPTH  = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  output logic                           MCU_RST,
  input  logic [31:0]                    IOBUS_ADDR,
  input  logic [31:0]                    IOBUS_OUT,
  input  logic                           IOBUS_WR,
  output logic [31:0]                    IOBUS_IN,
  input  logic [32*NUM_CH-1:0]           CH_IN,
  output logic [32*NUM_CH-1:0]           CH_OUT,
  input  logic                           LOG_RD,
  output logic                           LOG_VALID,
  output logic [31:0]                    LOG_ADDR,
  output logic [31:0]                    LOG_DATA,
  output logic [$clog2(LOG_DEPTH+1)-1:0] LOG_COUNT,
  output logic                           LOG_OVF
);
  localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = $clog2(LOG_DEPTH + 1);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q;
  logic [RC_W-1:0]   rc_q;
  logic              mcu_rst_q;

  // Reset stretcher: MCU_RST stays high RST_CYCLES cycles past the last RST edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HOLD;
      rc_q      <= '0;
      mcu_rst_q <= 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (rc_q == RC_W'(RST_CYCLES - 1)) begin
            state_q   <= RUN;
            mcu_rst_q <= 1'b0;
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        RUN: mcu_rst_q <= 1'b0;
        default: begin
          state_q   <= HOLD;
          mcu_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign MCU_RST = mcu_rst_q;

  // Address decode; addresses below BASE_ADDR wrap high and miss.
  logic [29:0] word_idx_c;
  logic        hit_c;

  assign word_idx_c = 30'((IOBUS_ADDR - BASE_ADDR) >> 2);
  assign hit_c      = (IOBUS_ADDR[1:0] == 2'b00) && (word_idx_c < 30'(NUM_CH));

  always_comb begin
    IOBUS_IN = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (hit_c && (word_idx_c == 30'(k))) IOBUS_IN = CH_IN[32*k +: 32];
    end
  end

  logic [32*NUM_CH-1:0] ch_out_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_out_q <= '0;
    end else if (IOBUS_WR && !mcu_rst_q && hit_c) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (word_idx_c == 30'(k)) ch_out_q[32*k +: 32] <= IOBUS_OUT;
      end
    end
  end

  assign CH_OUT = ch_out_q;

  // Write log FIFO; a push into a full log is stored only when a pop frees the slot.
  logic [31:0]      log_addr_q [LOG_DEPTH];
  logic [31:0]      log_data_q [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push_c, pop_c, full_c, store_c;

  always_comb begin
    push_c   = IOBUS_WR && !mcu_rst_q;
    pop_c    = LOG_RD && (cnt_q != '0);
    full_c   = (cnt_q == CNT_W'(LOG_DEPTH));
    store_c  = push_c && (!full_c || pop_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q || (push_c && !store_c);
    if (store_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (store_c && !pop_c)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop_c && !store_c) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (store_c) begin
      log_addr_q[wr_ptr_q] <= IOBUS_ADDR;
      log_data_q[wr_ptr_q] <= IOBUS_OUT;
    end
  end

  assign LOG_VALID = (cnt_q != '0);
  assign LOG_ADDR  = log_addr_q[rd_ptr_q];
  assign LOG_DATA  = log_data_q[rd_ptr_q];
  assign LOG_COUNT = cnt_q;
  assign LOG_OVF   = ovf_q;

endmodule

// File: tb/tb_otter_io_harness.sv
// Bench for otter_io_harness: queue/array reference model checked every cycle,
// plus directed literal checks for reset, decode, logging, overflow and mid-run reset.
module tb_otter_io_harness;
  localparam int unsigned NUM_CH     = 4;
  localparam logic [31:0] BASE       = 32'h1100_0000;
  localparam int unsigned RST_CYCLES = 3;
  localparam int unsigned DEPTH      = 8;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  MCU_RST;
  logic [31:0]           IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic                  IOBUS_WR;
  logic [32*NUM_CH-1:0]  CH_IN, CH_OUT;
  logic                  LOG_RD, LOG_VALID, LOG_OVF;
  logic [31:0]           LOG_ADDR, LOG_DATA;
  logic [3:0]            LOG_COUNT;

  otter_io_harness #(
    .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .RST_CYCLES(RST_CYCLES), .LOG_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .MCU_RST(MCU_RST),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN), .CH_IN(CH_IN), .CH_OUT(CH_OUT),
    .LOG_RD(LOG_RD), .LOG_VALID(LOG_VALID), .LOG_ADDR(LOG_ADDR),
    .LOG_DATA(LOG_DATA), .LOG_COUNT(LOG_COUNT), .LOG_OVF(LOG_OVF)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: reset hold counter, channel array, log queue, sticky overflow.
  bit          m_on   = 1'b0;
  int          m_hold = 0;
  logic [31:0] m_ch [NUM_CH];
  logic [63:0] m_q [$];
  bit          m_ovf;
  bit          m_mrst, m_push, m_pop;
  int          m_idx;

  function automatic bit m_decode(input logic [31:0] a, output int idx);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    idx = 0;
    if (la >= lb && la < lb + 4 * longint'(NUM_CH) && (la % 4) == 0) begin
      idx = int'((la - lb) / 4);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int i;
    if (m_decode(a, i)) return CH_IN[32*i +: 32];
    return 32'h0;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_on   = 1'b1;
      m_hold = RST_CYCLES;
      for (int k = 0; k < NUM_CH; k++) m_ch[k] = 32'h0;
      m_q.delete();
      m_ovf  = 1'b0;
    end else if (m_on) begin
      m_mrst = (m_hold > 0);
      m_push = IOBUS_WR && !m_mrst;
      m_pop  = LOG_RD && (m_q.size() > 0);
      if (m_push && m_decode(IOBUS_ADDR, m_idx)) m_ch[m_idx] = IOBUS_OUT;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back({IOBUS_ADDR, IOBUS_OUT});
        else m_ovf = 1'b1;
      end
      if (m_hold > 0) m_hold--;
    end
  end

  always @(negedge CLK) begin
    if (m_on) begin
      check("mcu_rst", 32'(MCU_RST), 32'(m_hold > 0));
      for (int k = 0; k < NUM_CH; k++) check("ch_out", CH_OUT[32*k +: 32], m_ch[k]);
      check("iobus_in", IOBUS_IN, m_read(IOBUS_ADDR));
      check("log_valid", 32'(LOG_VALID), 32'(m_q.size() != 0));
      check("log_count", 32'(LOG_COUNT), 32'(m_q.size()));
      check("log_ovf", 32'(LOG_OVF), 32'(m_ovf));
      if (m_q.size() != 0) begin
        check("log_addr", LOG_ADDR, m_q[0][63:32]);
        check("log_data", LOG_DATA, m_q[0][31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic chk_ch_zero(input string name);
    for (int k = 0; k < NUM_CH; k++) check(name, CH_OUT[32*k +: 32], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; IOBUS_WR = 1'b0; LOG_RD = 1'b0;
    IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0;
    CH_IN = {32'h3333_3333, 32'h0000_0002, 32'h1111_1111, 32'hA000_0000};

    // Reset for two edges, then release and count the stretched MCU reset.
    tick(); tick();
    check("rst_mcu_rst", 32'(MCU_RST), 32'h1);
    check("rst_valid", 32'(LOG_VALID), 32'h0);
    check("rst_count", 32'(LOG_COUNT), 32'h0);
    check("rst_ovf", 32'(LOG_OVF), 32'h0);
    chk_ch_zero("rst_ch_out");
    RST = 1'b0;
    tick(); check("hold1", 32'(MCU_RST), 32'h1);
    tick(); check("hold2", 32'(MCU_RST), 32'h1);
    tick(); check("hold3_release", 32'(MCU_RST), 32'h0);

    // Combinational read decode.
    IOBUS_ADDR = 32'h1100_0008; #1; check("rd_ch2", IOBUS_IN, 32'h0000_0002);
    IOBUS_ADDR = 32'h1100_000C; #1; check("rd_ch3", IOBUS_IN, 32'h3333_3333);
    IOBUS_ADDR = 32'h1100_0010; #1; check("rd_past_end", IOBUS_IN, 32'h0);
    IOBUS_ADDR = 32'h1100_0009; #1; check("rd_unaligned", IOBUS_IN, 32'h0);
    IOBUS_ADDR = 32'h10FF_FFFC; #1; check("rd_below_base", IOBUS_IN, 32'h0);

    // Hit write, then miss write.
    wr(32'h1100_0004, 32'hDEAD_BEEF);
    check("wr_ch1", CH_OUT[63:32], 32'hDEAD_BEEF);
    check("wr_valid", 32'(LOG_VALID), 32'h1);
    check("wr_log_addr", LOG_ADDR, 32'h1100_0004);
    check("wr_log_data", LOG_DATA, 32'hDEAD_BEEF);
    check("wr_count", 32'(LOG_COUNT), 32'h1);
    wr(32'h0000_0100, 32'h5555_5555);
    check("miss_ch1", CH_OUT[63:32], 32'hDEAD_BEEF);
    check("miss_ch0", CH_OUT[31:0], 32'h0);
    check("miss_count", 32'(LOG_COUNT), 32'h2);

    // Drain, then pop while empty.
    LOG_RD = 1'b1; tick();
    check("pop_head", LOG_ADDR, 32'h0000_0100);
    tick();
    check("drained", 32'(LOG_VALID), 32'h0);
    tick();
    check("pop_empty", 32'(LOG_COUNT), 32'h0);
    LOG_RD = 1'b0;

    // Overflow: 9 writes into an 8-deep log.
    for (int d = 1; d <= 9; d++) wr(32'h1100_0000, 32'(d));
    check("ovf_count", 32'(LOG_COUNT), 32'h8);
    check("ovf_flag", 32'(LOG_OVF), 32'h1);
    check("ovf_ch0", CH_OUT[31:0], 32'h9);
    check("ovf_head", LOG_DATA, 32'h1);

    // Push and pop together while full.
    IOBUS_ADDR = 32'h1100_0000; IOBUS_OUT = 32'hA; IOBUS_WR = 1'b1; LOG_RD = 1'b1;
    tick();
    IOBUS_WR = 1'b0; LOG_RD = 1'b0;
    check("full_pp_count", 32'(LOG_COUNT), 32'h8);
    check("full_pp_ovf", 32'(LOG_OVF), 32'h1);
    for (int d = 2; d <= 8; d++) begin
      check("drain_order", LOG_DATA, 32'(d));
      LOG_RD = 1'b1; tick(); LOG_RD = 1'b0;
    end
    check("drain_last", LOG_DATA, 32'hA);
    LOG_RD = 1'b1; tick(); LOG_RD = 1'b0;
    check("drain_empty", 32'(LOG_COUNT), 32'h0);

    // Mid-run reset with populated log and channels.
    wr(32'h1100_0008, 32'h22);
    wr(32'h1100_000C, 32'h33);
    wr(32'h0000_0200, 32'h44);
    check("pre_rst_count", 32'(LOG_COUNT), 32'h3);
    RST = 1'b1; tick(); RST = 1'b0;
    check("mid_rst_mcu", 32'(MCU_RST), 32'h1);
    check("mid_rst_count", 32'(LOG_COUNT), 32'h0);
    check("mid_rst_valid", 32'(LOG_VALID), 32'h0);
    check("mid_rst_ovf", 32'(LOG_OVF), 32'h0);
    chk_ch_zero("mid_rst_ch_out");
    wr(32'h1100_0008, 32'h77);
    check("held_wr_ch2", CH_OUT[95:64], 32'h0);
    check("held_wr_count", 32'(LOG_COUNT), 32'h0);
    check("held_mcu1", 32'(MCU_RST), 32'h1);
    tick(); check("held_mcu2", 32'(MCU_RST), 32'h1);
    tick(); check("held_release", 32'(MCU_RST), 32'h0);
    wr(32'h1100_0008, 32'h1234);
    check("resume_ch2", CH_OUT[95:64], 32'h1234);
    check("resume_count", 32'(LOG_COUNT), 32'h1);
    check("resume_addr", LOG_ADDR, 32'h1100_0008);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
